// File: rtl/posit_pkg.sv
// Shared width helpers, special-value constants and the stage-1 -> stage-2 record
// used by the pipelined posit encoder.
package posit_pkg;

  localparam int POSIT_MAX_N = 32;

  function automatic int sf_width(input int n, input int es);
    return $clog2(n) + es + 1;
  endfunction

  function automatic int mant_width(input int n, input int es);
    return n - 3 - es;
  endfunction

  function automatic logic [POSIT_MAX_N-1:0] posit_nar(input int n);
    return POSIT_MAX_N'(1) << (n - 1);
  endfunction

  function automatic logic [POSIT_MAX_N-1:0] posit_zero(input int n);
    return POSIT_MAX_N'(0) & ~(POSIT_MAX_N'(0) << n);
  endfunction

  function automatic logic [POSIT_MAX_N-1:0] posit_maxpos(input int n);
    return (POSIT_MAX_N'(1) << (n - 1)) - POSIT_MAX_N'(1);
  endfunction

  function automatic logic [POSIT_MAX_N-1:0] posit_minpos(input int n);
    return POSIT_MAX_N'(n > 0);
  endfunction

  // mag is sized for the widest posit; narrower instances use mag[N-2:0]
  typedef struct packed {
    logic                   s;
    logic                   nar;
    logic                   nzn;
    logic                   sat;
    logic [POSIT_MAX_N-2:0] mag;
    logic                   rnd;
    logic                   stk;
  } posit_stage_t;

endpackage

// File: rtl/posit_encoder_pipe_if.sv
// Valid/ready bus of posit_encoder_pipe; o_inexact/o_sat exist only when
// POSIT_ENC_FLAGS_EN is defined.
interface posit_encoder_pipe_if #(
  parameter int N  = 16,
  parameter int ES = 1
);
  localparam int SF_W   = posit_pkg::sf_width(N, ES);
  localparam int MANT_W = posit_pkg::mant_width(N, ES);

  logic              i_valid;
  logic              o_ready;
  logic              i_s;
  logic [SF_W-1:0]   i_sf;
  logic [MANT_W-1:0] i_mant;
  logic              i_guard;
  logic              i_sticky;
  logic              i_nzn;
  logic              i_nar;
  logic              o_valid;
  logic              i_ready;
  logic [N-1:0]      o_r;
`ifdef POSIT_ENC_FLAGS_EN
  logic              o_inexact;
  logic              o_sat;
`endif

  modport master (
    output i_valid, i_s, i_sf, i_mant, i_guard, i_sticky, i_nzn, i_nar, i_ready,
    input  o_ready, o_valid, o_r
`ifdef POSIT_ENC_FLAGS_EN
    , input o_inexact, o_sat
`endif
  );

  modport slave (
    input  i_valid, i_s, i_sf, i_mant, i_guard, i_sticky, i_nzn, i_nar, i_ready,
    output o_ready, o_valid, o_r
`ifdef POSIT_ENC_FLAGS_EN
    , output o_inexact, o_sat
`endif
  );

endinterface

// File: rtl/posit_rshift_sticky.sv
// Right shift that fills vacated MSBs with a pad bit and ORs every bit shifted
// out of the LSB end into sticky.
module posit_rshift_sticky #(
  parameter int W    = 16,
  parameter int SH_W = 4
) (
  input  logic [W-1:0]    din,
  input  logic [SH_W-1:0] sh,
  input  logic            pad,
  output logic [W-1:0]    dout,
  output logic            sticky
);
  logic [W-1:0] hi_unused;
  logic [W-1:0] low_mask;

  assign {hi_unused, dout} = {{W{pad}}, din} >> sh;

  for (genvar gi = 0; gi < W; gi++) begin : g_mask
    assign low_mask[gi] = (32'(gi) < 32'(sh));
  end

  assign sticky = |(din & low_mask);

endmodule

// File: rtl/posit_encoder_pipe.sv
// Two-stage posit<N,ES> encoder: stage 1 builds regime/exponent/fraction and
// saturates, stage 2 rounds to nearest even and applies sign/specials.
// Optional flag outputs are enabled with POSIT_ENC_FLAGS_EN.
module posit_encoder_pipe
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  posit_encoder_pipe_if.slave bus
);
  localparam int SF_W   = sf_width(N, ES);
  localparam int MANT_W = mant_width(N, ES);
  localparam int SH_W   = $clog2(N);
  localparam logic [N-1:0] NAR_VAL    = N'(posit_nar(N));
  localparam logic [N-1:0] ZERO_VAL   = N'(posit_zero(N));
  localparam logic [N-2:0] MAXPOS_MAG = (N-1)'(posit_maxpos(N));
  localparam logic [N-2:0] MINPOS_MAG = (N-1)'(posit_minpos(N));

  logic         en_reg;
  logic         v1_reg, v2_reg;
  posit_stage_t rec1_reg, rec1_next;
  logic [N-1:0] r_reg, r_next;
  logic         rdy1, rdy2, accept;

  assign rdy2        = !v2_reg | bus.i_ready;
  assign rdy1        = !v1_reg | rdy2;
  assign bus.o_ready = en_reg & rdy1;
  assign accept      = bus.i_valid & bus.o_ready;
  assign bus.o_valid = v2_reg;
  assign bus.o_r     = r_reg;

  // ---------------- stage 1: regime construction ----------------
  logic signed [SF_W-1:0] sf, k;
  logic [MANT_W-1:0]      mant;
  logic                   k_neg;
  logic [N-2:0]           word;
  logic [SH_W-1:0]        sh;
  logic [N-1:0]           shifted;
  logic                   dropped;
  int                     k_int;

  assign sf    = $signed(bus.i_sf);
  assign k     = sf >>> ES;
  assign k_neg = sf[SF_W-1];
  assign mant  = bus.i_mant;

  // The first bit after the regime run terminates it, so it is the inverse of the run value
  if (ES > 0) begin : g_exp
    assign word = {k_neg, bus.i_sf[ES-1:0], mant, bus.i_guard};
  end else begin : g_noexp
    assign word = {k_neg, mant, bus.i_guard};
  end

  always_comb begin
    k_int = int'(k);
    sh    = k_neg ? SH_W'(-k_int) : SH_W'(k_int + 1);
  end

  posit_rshift_sticky #(.W(N), .SH_W(SH_W)) u_shift (
    .din    ({word, 1'b0}),
    .sh     (sh),
    .pad    (!k_neg),
    .dout   (shifted),
    .sticky (dropped)
  );

  always_comb begin
    rec1_next     = '0;
    rec1_next.s   = bus.i_s;
    rec1_next.nar = bus.i_nar;
    rec1_next.nzn = bus.i_nzn;
    if (k_int >= N - 2) begin
      rec1_next.sat        = 1'b1;
      rec1_next.mag[N-2:0] = MAXPOS_MAG;
      rec1_next.stk        = 1'b1;
    end else if (k_int <= -(N - 1)) begin
      rec1_next.sat        = 1'b1;
      rec1_next.mag[N-2:0] = MINPOS_MAG;
      rec1_next.stk        = 1'b1;
    end else begin
      rec1_next.mag[N-2:0] = shifted[N-1:1];
      rec1_next.rnd        = shifted[0];
      rec1_next.stk        = bus.i_sticky | dropped;
    end
  end

  // ---------------- stage 2: RNE, clamp, sign, specials ----------------
  logic [N-2:0] mag1, mag_fin;
  logic [N-1:0] sum;
  logic         round_up;

  assign mag1     = rec1_reg.mag[N-2:0];
  assign round_up = rec1_reg.rnd & (mag1[0] | rec1_reg.stk) & !rec1_reg.sat;
  assign sum      = {1'b0, mag1} + {{(N-1){1'b0}}, round_up};

  always_comb begin
    mag_fin = sum[N-1] ? MAXPOS_MAG : sum[N-2:0];
    r_next  = ZERO_VAL;
    if (rec1_reg.nar) begin
      r_next = NAR_VAL;
    end else if (rec1_reg.nzn) begin
      r_next = rec1_reg.s ? -{1'b0, mag_fin} : {1'b0, mag_fin};
    end
  end

  if (N < POSIT_MAX_N) begin : g_mag_pad
    logic mag_pad_unused;
    assign mag_pad_unused = ^rec1_reg.mag[POSIT_MAX_N-2:N-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg   <= 1'b0;
      v1_reg   <= 1'b0;
      rec1_reg <= '0;
      v2_reg   <= 1'b0;
      r_reg    <= '0;
    end else begin
      en_reg <= 1'b1;
      if (rdy1)   v1_reg   <= accept;
      if (accept) rec1_reg <= rec1_next;
      if (rdy2)   v2_reg   <= v1_reg;
      if (rdy2 && v1_reg) r_reg <= r_next;
    end
  end

`ifdef POSIT_ENC_FLAGS_EN
  logic inexact_reg, sat_reg;

  // Saturated results are reported as inexact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inexact_reg <= 1'b0;
      sat_reg     <= 1'b0;
    end else if (rdy2 && v1_reg) begin
      inexact_reg <= rec1_reg.nzn & !rec1_reg.nar & (rec1_reg.rnd | rec1_reg.stk);
      sat_reg     <= rec1_reg.nzn & !rec1_reg.nar & rec1_reg.sat;
    end
  end

  assign bus.o_inexact = inexact_reg;
  assign bus.o_sat     = sat_reg;
`endif

endmodule
